// File: rtl/xif_copro_instr_pkg.sv
// XIF coprocessor instruction encodings: custom-0 opcode, funct3 selectors and execute op codes.
package xif_copro_instr_pkg;
    localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;
    localparam logic [2:0] F3_BITREV   = 3'b000;
    localparam logic [2:0] F3_BYTEREV  = 3'b001;
    localparam logic [2:0] F3_POPCNT   = 3'b010;
    localparam logic [2:0] F3_CLZ      = 3'b011;
    localparam logic [1:0] OP_BITREV   = 2'd0;
    localparam logic [1:0] OP_BYTEREV  = 2'd1;
    localparam logic [1:0] OP_POPCNT   = 2'd2;
    localparam logic [1:0] OP_CLZ      = 2'd3;
endpackage

// File: rtl/xif_copro_issue_queue_if.sv
// XIF issue/commit plus execute-side valid/ready bundle; master = core/execute side, slave = issue queue.
interface xif_copro_issue_queue_if #(
    parameter int XLEN     = 32,
    parameter int ID_WIDTH = 4
);
    logic                issue_valid_i;
    logic                issue_ready_o;
    logic [31:0]         issue_instr_i;
    logic [ID_WIDTH-1:0] issue_id_i;
    logic [XLEN-1:0]     issue_rs_i;
    logic                issue_rs_valid_i;
    logic                issue_accept_o;
    logic                issue_writeback_o;
    logic                commit_valid_i;
    logic [ID_WIDTH-1:0] commit_id_i;
    logic                commit_kill_i;
    logic                out_valid_o;
    logic                out_ready_i;
    logic [1:0]          out_op_o;
    logic [XLEN-1:0]     out_rs_o;
    logic [ID_WIDTH-1:0] out_id_o;

    modport master (
        output issue_valid_i, issue_instr_i, issue_id_i, issue_rs_i, issue_rs_valid_i,
        output commit_valid_i, commit_id_i, commit_kill_i, out_ready_i,
        input  issue_ready_o, issue_accept_o, issue_writeback_o,
        input  out_valid_o, out_op_o, out_rs_o, out_id_o
    );

    modport slave (
        input  issue_valid_i, issue_instr_i, issue_id_i, issue_rs_i, issue_rs_valid_i,
        input  commit_valid_i, commit_id_i, commit_kill_i, out_ready_i,
        output issue_ready_o, issue_accept_o, issue_writeback_o,
        output out_valid_o, out_op_o, out_rs_o, out_id_o
    );
endinterface

// File: rtl/xif_copro_issue_queue.sv
// In-order XIF issue queue: combinational issue decode, head shown 1 cycle after commit, stalls on uncommitted head.
// XIF_COPRO_EXT_OPS_EN enables BYTEREV/POPCNT/CLZ decode; otherwise only BITREV is recognised.
module xif_copro_issue_queue #(
    parameter int DEPTH    = 4,
    parameter int XLEN     = 32,
    parameter int ID_WIDTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    xif_copro_issue_queue_if.slave       bus,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    import xif_copro_instr_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [1:0]          op_q   [DEPTH];
    logic [XLEN-1:0]     rs_q   [DEPTH];
    logic [ID_WIDTH-1:0] id_q   [DEPTH];
    logic                vld_q  [DEPTH];
    logic                cmt_q  [DEPTH];
    logic                kill_q [DEPTH];
    logic [1:0]          op_d   [DEPTH];
    logic [XLEN-1:0]     rs_d   [DEPTH];
    logic [ID_WIDTH-1:0] id_d   [DEPTH];
    logic                vld_d  [DEPTH];
    logic                cmt_d  [DEPTH];
    logic                kill_d [DEPTH];

    logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic                out_vld_q, out_vld_d;
    logic [1:0]          out_op_q, out_op_d;
    logic [XLEN-1:0]     out_rs_q, out_rs_d;
    logic [ID_WIDTH-1:0] out_id_q, out_id_d;

    logic       base_ok, dec_recog, full, push, pop, new_match;
    logic [1:0] dec_op;
    logic [2:0] f3;
    logic       unused_instr_bits;

    assign f3      = bus.issue_instr_i[14:12];
    assign base_ok = (bus.issue_instr_i[6:0] == OPC_CUSTOM0) &&
                     (bus.issue_instr_i[31:25] == 7'b0) &&
                     (bus.issue_instr_i[24:20] == 5'b0);
    assign unused_instr_bits = ^{bus.issue_instr_i[19:15], bus.issue_instr_i[11:7]};

`ifdef XIF_COPRO_EXT_OPS_EN
    always_comb begin
        dec_recog = base_ok;
        dec_op    = OP_BITREV;
        case (f3)
            F3_BITREV:  dec_op = OP_BITREV;
            F3_BYTEREV: dec_op = OP_BYTEREV;
            F3_POPCNT:  dec_op = OP_POPCNT;
            F3_CLZ:     dec_op = OP_CLZ;
            default:    dec_recog = 1'b0;
        endcase
    end
`else
    assign dec_recog = base_ok && (f3 == F3_BITREV);
    assign dec_op    = OP_BITREV;
`endif

    // Unrecognised words complete the handshake regardless of rs validity or fullness.
    assign full                  = (count_q == CW'(DEPTH));
    assign bus.issue_ready_o     = !rst_i && (dec_recog ? (!full && bus.issue_rs_valid_i) : 1'b1);
    assign bus.issue_accept_o    = bus.issue_valid_i && bus.issue_ready_o && dec_recog;
    assign bus.issue_writeback_o = bus.issue_accept_o;

    assign push      = bus.issue_accept_o;
    assign pop       = vld_q[rd_ptr_q] && (kill_q[rd_ptr_q] || (out_vld_q && bus.out_ready_i));
    assign new_match = bus.commit_valid_i && (bus.commit_id_i == bus.issue_id_i);

    always_comb begin
        op_d     = op_q;
        rs_d     = rs_q;
        id_d     = id_q;
        vld_d    = vld_q;
        cmt_d    = cmt_q;
        kill_d   = kill_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        if (bus.commit_valid_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (vld_q[i] && (id_q[i] == bus.commit_id_i)) begin
                    if (bus.commit_kill_i) kill_d[i] = 1'b1;
                    else                   cmt_d[i]  = 1'b1;
                end
            end
        end
        if (push) begin
            op_d[wr_ptr_q]   = dec_op;
            rs_d[wr_ptr_q]   = bus.issue_rs_i;
            id_d[wr_ptr_q]   = bus.issue_id_i;
            vld_d[wr_ptr_q]  = 1'b1;
            cmt_d[wr_ptr_q]  = new_match && !bus.commit_kill_i;
            kill_d[wr_ptr_q] = new_match && bus.commit_kill_i;
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            vld_d[rd_ptr_q]  = 1'b0;
            cmt_d[rd_ptr_q]  = 1'b0;
            kill_d[rd_ptr_q] = 1'b0;
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        // Out port is registered from the next head state so it holds steady until popped.
        out_vld_d = vld_d[rd_ptr_d] && cmt_d[rd_ptr_d] && !kill_d[rd_ptr_d];
        out_op_d  = out_vld_d ? op_d[rd_ptr_d] : '0;
        out_rs_d  = out_vld_d ? rs_d[rd_ptr_d] : '0;
        out_id_d  = out_vld_d ? id_d[rd_ptr_d] : '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i]   <= '0;
                rs_q[i]   <= '0;
                id_q[i]   <= '0;
                vld_q[i]  <= 1'b0;
                cmt_q[i]  <= 1'b0;
                kill_q[i] <= 1'b0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            out_vld_q <= 1'b0;
            out_op_q  <= '0;
            out_rs_q  <= '0;
            out_id_q  <= '0;
        end else begin
            op_q      <= op_d;
            rs_q      <= rs_d;
            id_q      <= id_d;
            vld_q     <= vld_d;
            cmt_q     <= cmt_d;
            kill_q    <= kill_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            out_vld_q <= out_vld_d;
            out_op_q  <= out_op_d;
            out_rs_q  <= out_rs_d;
            out_id_q  <= out_id_d;
        end
    end

    assign bus.out_valid_o = out_vld_q;
    assign bus.out_op_o    = out_op_q;
    assign bus.out_rs_o    = out_rs_q;
    assign bus.out_id_o    = out_id_q;
    assign count_o         = count_q;
endmodule
